// File: rtl/debug_ctrl.sv
// debug_ctrl: UART command decoder that steps, runs and resets the pipeline and streams a
// reason byte plus snapshot after each halt. Breakpoint support is enabled by DEBUG_CTRL_BREAKPOINT_EN.
module debug_ctrl #(
    parameter int DATA_BYTES = 168,
    parameter int HALT_NOPS  = 5,
    parameter int PC_W       = 7,
    parameter int MAX_CYCLES = 4096,
    parameter int RST_CYCLES = 1
) (
    input  logic                    top_clk,
    input  logic                    top_rst_n,
    input  logic                    rx_done_tick,
    input  logic [7:0]              rx_bus,
    input  logic                    tx_done_tick,
    input  logic [31:0]             instruccion,
    input  logic [PC_W-1:0]         pc,
    input  logic [DATA_BYTES*8-1:0] send_data,
    output logic                    clk_pipe,
    output logic                    rst_pipe,
    output logic                    tx_start,
    output logic [7:0]              tx_bus,
    output logic                    busy
);
    localparam int BUF_W = (DATA_BYTES + 1) * 8;
    localparam int REM_W = $clog2(DATA_BYTES + 2);
    localparam int NOP_W = (HALT_NOPS > 0) ? $clog2(HALT_NOPS + 1) : 1;
    localparam int CYC_W = (MAX_CYCLES > 0) ? $clog2(MAX_CYCLES + 1) : 1;
    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [REM_W-1:0] REM_INIT  = REM_W'(DATA_BYTES + 1);
    localparam logic [NOP_W-1:0] NOP_LIMIT = NOP_W'(HALT_NOPS);
    localparam logic [CYC_W-1:0] CYC_LIMIT = CYC_W'(MAX_CYCLES);
    localparam logic [CYC_W-1:0] CYC_SAT   = '1;
    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CYCLES - 1);

    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_RUN  = 8'h63;
    localparam logic [7:0] CMD_RST  = 8'h72;
    localparam logic [7:0] CMD_BP   = 8'h62;
    localparam logic [7:0] CMD_HALT = 8'h68;

    localparam logic [7:0] REASON_STEP  = 8'h53;
    localparam logic [7:0] REASON_ABORT = 8'h48;
    localparam logic [7:0] REASON_BP    = 8'h42;
    localparam logic [7:0] REASON_NOP   = 8'h4E;
    localparam logic [7:0] REASON_WDOG  = 8'h57;

    typedef enum logic [3:0] {
        IDLE,
        STEP_HI,
        STEP_LO,
        CAPTURE,
        RUN_CHK,
        RUN_HI,
        RUN_LO,
        RST_HI,
        RST_LO,
        BP_WAIT,
        SEND_START,
        SEND_WAIT
    } state_t;

    state_t           state_reg, state_next;
    logic [BUF_W-1:0] buf_reg, buf_next;
    logic [REM_W-1:0] rem_reg, rem_next;
    logic [NOP_W-1:0] nop_reg, nop_next;
    logic [CYC_W-1:0] cyc_reg, cyc_next;
    logic [RST_W-1:0] rst_cnt_reg, rst_cnt_next;
    logic [7:0]       reason_reg, reason_next;
    logic             abort_reg, abort_next;
    logic             clk_pipe_reg, rst_pipe_reg, tx_start_reg, busy_reg;
    logic             buf_load, buf_shift;

    logic [7:0] cmd;
    logic       halt_rx, abort_now, bp_hit, nop_hit, wd_hit;
    logic       run_halt;
    logic [7:0] run_reason;

    // Folding in bit 5 makes the lowercase compare match both cases.
    assign cmd       = rx_bus | 8'h20;
    assign halt_rx   = rx_done_tick && (cmd == CMD_HALT);
    assign abort_now = abort_reg || halt_rx;
    assign nop_hit   = (nop_reg == NOP_LIMIT);
    assign wd_hit    = (MAX_CYCLES != 0) && (cyc_reg == CYC_LIMIT);

`ifdef DEBUG_CTRL_BREAKPOINT_EN
    logic [PC_W-1:0] bp_reg, bp_next;
    logic            bp_armed_reg, bp_armed_next;

    // A zero cycle count means the run has not moved yet, so starting on the breakpoint does not re-hit it.
    assign bp_hit = bp_armed_reg && (cyc_reg != '0) && (pc == bp_reg);
`else
    logic unused_pc;

    assign unused_pc = ^pc;
    assign bp_hit    = 1'b0;
`endif

    always_comb begin
        run_halt   = 1'b1;
        run_reason = REASON_ABORT;
        if (abort_now) begin
            run_reason = REASON_ABORT;
        end else if (bp_hit) begin
            run_reason = REASON_BP;
        end else if (nop_hit) begin
            run_reason = REASON_NOP;
        end else if (wd_hit) begin
            run_reason = REASON_WDOG;
        end else begin
            run_halt = 1'b0;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rem_next     = rem_reg;
        nop_next     = nop_reg;
        cyc_next     = cyc_reg;
        rst_cnt_next = rst_cnt_reg;
        reason_next  = reason_reg;
        abort_next   = abort_reg;
        buf_load     = 1'b0;
        buf_shift    = 1'b0;
`ifdef DEBUG_CTRL_BREAKPOINT_EN
        bp_next       = bp_reg;
        bp_armed_next = bp_armed_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (rx_done_tick) begin
                    case (cmd)
                        CMD_STEP: begin
                            reason_next = REASON_STEP;
                            state_next  = STEP_HI;
                        end
                        CMD_RUN: begin
                            nop_next   = '0;
                            cyc_next   = '0;
                            abort_next = 1'b0;
                            state_next = RUN_CHK;
                        end
                        CMD_RST: begin
                            rst_cnt_next = '0;
                            state_next   = RST_HI;
                        end
                        CMD_BP: begin
`ifdef DEBUG_CTRL_BREAKPOINT_EN
                            state_next = BP_WAIT;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            STEP_HI: state_next = STEP_LO;
            STEP_LO: state_next = CAPTURE;
            CAPTURE: begin
                buf_load   = 1'b1;
                rem_next   = REM_INIT;
                state_next = SEND_START;
            end
            RUN_CHK: begin
                if (run_halt) begin
                    reason_next = run_reason;
                    abort_next  = 1'b0;
                    state_next  = CAPTURE;
                end else begin
                    if (instruccion != 32'd0) begin
                        nop_next = '0;
                    end else if (nop_reg != NOP_LIMIT) begin
                        nop_next = nop_reg + NOP_W'(1);
                    end
                    if (cyc_reg != CYC_SAT) begin
                        cyc_next = cyc_reg + CYC_W'(1);
                    end
                    state_next = RUN_HI;
                end
            end
            RUN_HI: begin
                if (halt_rx) abort_next = 1'b1;
                state_next = RUN_LO;
            end
            RUN_LO: begin
                if (halt_rx) abort_next = 1'b1;
                state_next = RUN_CHK;
            end
            RST_HI: state_next = RST_LO;
            RST_LO: begin
                if (rst_cnt_reg == RST_LAST) begin
                    nop_next   = '0;
                    state_next = IDLE;
                end else begin
                    rst_cnt_next = rst_cnt_reg + RST_W'(1);
                    state_next   = RST_HI;
                end
            end
            BP_WAIT: begin
`ifdef DEBUG_CTRL_BREAKPOINT_EN
                if (rx_done_tick) begin
                    if (rx_bus == 8'hFF) begin
                        bp_armed_next = 1'b0;
                    end else begin
                        bp_next       = rx_bus[PC_W-1:0];
                        bp_armed_next = 1'b1;
                    end
                    state_next = IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            SEND_START: state_next = SEND_WAIT;
            SEND_WAIT: begin
                if (tx_done_tick) begin
                    buf_shift  = 1'b1;
                    rem_next   = rem_reg - REM_W'(1);
                    state_next = (rem_reg != REM_W'(1)) ? SEND_START : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Each lane either loads its frame byte or takes the byte above it as the frame drains.
    genvar gi;
    generate
        for (gi = 0; gi <= DATA_BYTES; gi++) begin : g_lane
            logic [7:0] load_byte;
            logic [7:0] shift_byte;
            if (gi == 0) begin : g_reason
                assign load_byte = reason_reg;
            end else begin : g_data
                assign load_byte = send_data[(gi-1)*8 +: 8];
            end
            if (gi == DATA_BYTES) begin : g_top
                assign shift_byte = 8'h00;
            end else begin : g_mid
                assign shift_byte = buf_reg[(gi+1)*8 +: 8];
            end
            assign buf_next[gi*8 +: 8] = buf_load  ? load_byte :
                                         buf_shift ? shift_byte : buf_reg[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge top_clk) begin
        if (!top_rst_n) begin
            state_reg    <= IDLE;
            buf_reg      <= '0;
            rem_reg      <= '0;
            nop_reg      <= '0;
            cyc_reg      <= '0;
            rst_cnt_reg  <= '0;
            reason_reg   <= '0;
            abort_reg    <= 1'b0;
            clk_pipe_reg <= 1'b0;
            rst_pipe_reg <= 1'b0;
            tx_start_reg <= 1'b0;
            busy_reg     <= 1'b0;
`ifdef DEBUG_CTRL_BREAKPOINT_EN
            bp_reg       <= '0;
            bp_armed_reg <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            buf_reg      <= buf_next;
            rem_reg      <= rem_next;
            nop_reg      <= nop_next;
            cyc_reg      <= cyc_next;
            rst_cnt_reg  <= rst_cnt_next;
            reason_reg   <= reason_next;
            abort_reg    <= abort_next;
            // Outputs decode the next state so they line up exactly with the state they belong to.
            clk_pipe_reg <= (state_next == STEP_HI) || (state_next == RUN_HI) || (state_next == RST_HI);
            rst_pipe_reg <= (state_next == RST_HI) || (state_next == RST_LO);
            tx_start_reg <= (state_next == SEND_START);
            busy_reg     <= (state_next != IDLE);
`ifdef DEBUG_CTRL_BREAKPOINT_EN
            bp_reg       <= bp_next;
            bp_armed_reg <= bp_armed_next;
`endif
        end
    end

    assign clk_pipe = clk_pipe_reg;
    assign rst_pipe = rst_pipe_reg;
    assign tx_start = tx_start_reg;
    assign busy     = busy_reg;
    assign tx_bus   = buf_reg[7:0];

endmodule
